tqvp_wdt_window: RTL and testbench

Parametrised second-generation watchdog peripheral for the TinyQV peripheral bus. It adds a programmable prescaler, an optional window mode that flags early taps, a configuration lock, and a two-stage expiry: an interrupt first, then a sticky reset request on `uo_out[0]` if the grace period also lapses. It sits in a peripheral slot alongside the other TinyQV user peripherals and uses the standard 6-bit-address, 8/16/32-bit read/write interface.

---
 rtl/tqvp_wdt_window.sv | 150 +++++++++++++++
 tb/tb_tqvp_wdt_window.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_wdt_window.sv
// Windowed watchdog peripheral for the TinyQV bus: prescaled countdown, interrupt, then sticky reset request.
// Optional window mode is compiled in with `define WDT_WINDOW_EN.
module tqvp_wdt_window #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PRE_W     = 16,
   parameter logic [31:0] TAP_MAGIC = 32'h0000ABCD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

`ifdef WDT_WINDOW_EN
   localparam bit WIN = 1'b1;
`else
   localparam bit WIN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED, S_RESET_REQ} state_t;

   state_t             state;
   logic               enable, window_en, lock;
   logic               started, timeout_pending, early_violation, reset_req;
   logic [CNT_W-1:0]   reload, window, counter;
   logic [PRE_W-1:0]   prescale, pre_cnt;

   logic [31:0]        wdata_c, rdata_c;
   logic               wr_c, rd_c, running_c, tick_c, start_c, tap_c, early_c;
   logic               unused_ui;

   assign unused_ui      = ^ui_in;
   assign uo_out         = {7'd0, reset_req};
   assign user_interrupt = timeout_pending;

   assign wr_c      = (data_write_n != 2'b11);
   assign rd_c      = (data_read_n != 2'b11);
   assign running_c = enable && (state == S_RUN || state == S_EXPIRED);
   assign tick_c    = running_c && (pre_cnt == prescale);
   assign start_c   = wr_c && (address == 6'd1) && (reload != '0) && (state != S_RESET_REQ);
   assign tap_c     = wr_c && (address == 6'd3) && (data_in == TAP_MAGIC) &&
                      (state == S_RUN || state == S_EXPIRED);
   assign early_c   = window_en && (state == S_RUN) && (counter > window);

   // Narrow writes zero-extend before truncation to the register width
   always_comb begin
      wdata_c = data_in;
      if (data_write_n == 2'b00)      wdata_c = {24'd0, data_in[7:0]};
      else if (data_write_n == 2'b01) wdata_c = {16'd0, data_in[15:0]};
   end

   always_comb begin
      rdata_c = 32'hFFFF_FFFF;
      case (address)
         6'd0:       rdata_c = {29'd0, lock, window_en, enable};
         6'd1, 6'd3: rdata_c = 32'd0;
         6'd2:       rdata_c = 32'(reload);
         6'd4:       rdata_c = {26'd0, (counter != '0), reset_req, early_violation,
                                timeout_pending, started, enable};
         6'd5:       rdata_c = 32'(window);
         6'd6:       rdata_c = 32'(prescale);
         6'd7:       rdata_c = 32'(counter);
         default:    rdata_c = 32'hFFFF_FFFF;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         enable          <= 1'b0;
         window_en       <= 1'b0;
         lock            <= 1'b0;
         started         <= 1'b0;
         timeout_pending <= 1'b0;
         early_violation <= 1'b0;
         reset_req       <= 1'b0;
         reload          <= '0;
         window          <= '0;
         counter         <= '0;
         prescale        <= '0;
         pre_cnt         <= '0;
         data_out        <= 32'd0;
         data_ready      <= 1'b0;
      end else begin
         data_ready <= rd_c;
         if (rd_c) data_out <= rdata_c;

         // Configuration writes; lock freezes them until reset
         if (wr_c && !lock) begin
            case (address)
               6'd0: begin
                  enable    <= wdata_c[0];
                  window_en <= WIN & wdata_c[1];
                  lock      <= wdata_c[2];
               end
               6'd2: reload <= CNT_W'(wdata_c);
               6'd5: if (WIN) window <= CNT_W'(wdata_c);
               6'd6: prescale <= PRE_W'(wdata_c);
               default: ;
            endcase
         end

         // Priority: START, then tap, then tick
         if (start_c) begin
            counter         <= reload;
            pre_cnt         <= '0;
            enable          <= 1'b1;
            started         <= 1'b1;
            timeout_pending <= 1'b0;
            state           <= S_RUN;
         end else if (tap_c) begin
            counter <= reload;
            pre_cnt <= '0;
            if (early_c) begin
               early_violation <= 1'b1;
               timeout_pending <= 1'b1;
               state           <= S_EXPIRED;
            end else begin
               timeout_pending <= 1'b0;
               state           <= S_RUN;
            end
         end else if (tick_c) begin
            pre_cnt <= '0;
            if (counter == CNT_W'(1)) begin
               if (state == S_RUN) begin
                  counter         <= reload;
                  timeout_pending <= 1'b1;
                  state           <= S_EXPIRED;
               end else begin
                  counter   <= '0;
                  reset_req <= 1'b1;
                  state     <= S_RESET_REQ;
               end
            end else begin
               counter <= counter - CNT_W'(1);
            end
         end else if (running_c) begin
            pre_cnt <= pre_cnt + PRE_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_tqvp_wdt_window.sv
// Directed testbench for tqvp_wdt_window: expiry, prescaler, taps, window, lock and bus reads.
module tb_tqvp_wdt_window;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  ui_in;
   logic [7:0]  uo_out;
   logic [5:0]  address;
   logic [31:0] data_in;
   logic [1:0]  data_write_n;
   logic [1:0]  data_read_n;
   logic [31:0] data_out;
   logic        data_ready;
   logic        user_interrupt;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd;
   logic        rdy;

   tqvp_wdt_window dut (
      .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out), .address(address),
      .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
      .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
      @(negedge clk);
      address = a; data_in = d; data_write_n = w;
      @(posedge clk); #1;
      data_write_n = 2'b11;
   endtask

   task automatic bus_read(input logic [5:0] a, output logic [31:0] d, output logic r);
      @(negedge clk);
      address = a; data_read_n = 2'b10;
      @(posedge clk); #1;
      data_read_n = 2'b11;
      d = data_out; r = data_ready;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out got %h exp 00", uo_out); end
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", user_interrupt); end
      n_checks++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", data_out); end
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready got %b exp 0", data_ready); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h0 || rdy !== 1'b1) begin n_fail++; $display("FAIL reset_status got %h/%b exp 0/1", rd, rdy); end
   endtask

   task automatic test_basic_expiry();
      do_reset();
      bus_write(6'd2, 32'd5, 2'b10);
      bus_write(6'd6, 32'd0, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (4) @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL basic_irq_early got %b exp 0", user_interrupt); end
      @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b1 || uo_out !== 8'h00) begin n_fail++; $display("FAIL basic_irq got %b/%h exp 1/00", user_interrupt, uo_out); end
      repeat (4) @(posedge clk); #1;
      n_checks++; if (uo_out !== 8'h00) begin n_fail++; $display("FAIL basic_rr_early got %h exp 00", uo_out); end
      @(posedge clk); #1;
      n_checks++; if (uo_out !== 8'h01) begin n_fail++; $display("FAIL basic_rr got %h exp 01", uo_out); end
      bus_write(6'd1, 32'd1, 2'b10);
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h17) begin n_fail++; $display("FAIL basic_status got %h exp 17", rd); end
      bus_read(6'd7, rd, rdy);
      n_checks++; if (rd !== 32'h0 || uo_out !== 8'h01) begin n_fail++; $display("FAIL basic_count got %h/%h exp 0/01", rd, uo_out); end
   endtask

   task automatic test_prescale_tap();
      do_reset();
      bus_write(6'd2, 32'd4, 2'b10);
      bus_write(6'd6, 32'd3, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (8) @(posedge clk);
      bus_read(6'd7, rd, rdy);
      n_checks++; if (rd !== 32'd2) begin n_fail++; $display("FAIL pre_count got %0d exp 2", rd); end
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      bus_write(6'd3, 32'h0000ABCE, 2'b10);
      bus_read(6'd7, rd, rdy);
      n_checks++; if (rd !== 32'd4) begin n_fail++; $display("FAIL pre_reload got %0d exp 4", rd); end
      repeat (13) @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL pre_irq_early got %b exp 0", user_interrupt); end
      @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL pre_irq got %b exp 1", user_interrupt); end
   endtask

   task automatic test_grace_recovery();
      do_reset();
      bus_write(6'd2, 32'd5, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (5) @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL grace_irq got %b exp 1", user_interrupt); end
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL grace_clear got %b exp 0", user_interrupt); end
      repeat (4) @(posedge clk); #1;
      n_checks++; if (uo_out !== 8'h00 || user_interrupt !== 1'b0) begin n_fail++; $display("FAIL grace_hold got %h/%b exp 00/0", uo_out, user_interrupt); end
      @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b1 || uo_out !== 8'h00) begin n_fail++; $display("FAIL grace_rerun got %b/%h exp 1/00", user_interrupt, uo_out); end
   endtask

   task automatic test_lock();
      do_reset();
      bus_write(6'd2, 32'd20, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      bus_write(6'd0, 32'h5, 2'b10);
      bus_write(6'd2, 32'd99, 2'b10);
      bus_write(6'd0, 32'h0, 2'b10);
      bus_read(6'd2, rd, rdy);
      n_checks++; if (rd !== 32'd20) begin n_fail++; $display("FAIL lock_reload got %0d exp 20", rd); end
      bus_read(6'd0, rd, rdy);
      n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL lock_ctrl got %h exp 5", rd); end
      bus_read(6'd7, rd, rdy);
      n_checks++; if (rd !== 32'd15) begin n_fail++; $display("FAIL lock_count got %0d exp 15", rd); end
      rst_n = 1'b0; #1;
      n_checks++; if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || data_out !== 32'h0 || data_ready !== 1'b0) begin
         n_fail++; $display("FAIL lock_async_rst got %h/%b/%h/%b exp all 0", uo_out, user_interrupt, data_out, data_ready);
      end
      @(negedge clk); rst_n = 1'b1;
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lock_idle_status got %h exp 0", rd); end
      bus_write(6'd2, 32'd7, 2'b10);
      bus_read(6'd2, rd, rdy);
      n_checks++; if (rd !== 32'd7) begin n_fail++; $display("FAIL lock_cleared got %0d exp 7", rd); end
   endtask

   task automatic test_reads();
      do_reset();
      bus_write(6'd2, 32'h1FF, 2'b00);
      bus_read(6'd2, rd, rdy);
      n_checks++; if (rd !== 32'hFF) begin n_fail++; $display("FAIL rd_w8 got %h exp ff", rd); end
      bus_write(6'd2, 32'h12345, 2'b01);
      bus_read(6'd2, rd, rdy);
      n_checks++; if (rd !== 32'h2345) begin n_fail++; $display("FAIL rd_w16 got %h exp 2345", rd); end
      bus_read(6'd9, rd, rdy);
      n_checks++; if (rd !== 32'hFFFFFFFF || rdy !== 1'b1) begin n_fail++; $display("FAIL rd_unmapped got %h/%b exp ffffffff/1", rd, rdy); end
      @(posedge clk); #1;
      n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL rd_ready_pulse got %b exp 0", data_ready); end
   endtask

   task automatic test_tap_vs_tick();
      do_reset();
      bus_write(6'd2, 32'd3, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (2) @(posedge clk);
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL tvt_irq got %b exp 0", user_interrupt); end
      repeat (2) @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL tvt_hold got %b exp 0", user_interrupt); end
      @(posedge clk); #1;
      n_checks++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL tvt_expire got %b exp 1", user_interrupt); end
   endtask

   task automatic test_window();
      do_reset();
      bus_write(6'd0, 32'h3, 2'b10);
      bus_write(6'd5, 32'd3, 2'b10);
      bus_write(6'd2, 32'd10, 2'b10);
`ifdef WDT_WINDOW_EN
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (3) @(posedge clk);
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      n_checks++; if (user_interrupt !== 1'b1) begin n_fail++; $display("FAIL win_early_irq got %b exp 1", user_interrupt); end
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h2F) begin n_fail++; $display("FAIL win_early_status got %h exp 2f", rd); end
      do_reset();
      bus_write(6'd0, 32'h3, 2'b10);
      bus_write(6'd5, 32'd3, 2'b10);
      bus_write(6'd2, 32'd10, 2'b10);
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (8) @(posedge clk);
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL win_ok_irq got %b exp 0", user_interrupt); end
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h23) begin n_fail++; $display("FAIL win_ok_status got %h exp 23", rd); end
`else
      bus_read(6'd0, rd, rdy);
      n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL nowin_ctrl got %h exp 1", rd); end
      bus_read(6'd5, rd, rdy);
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL nowin_window got %h exp 0", rd); end
      bus_write(6'd1, 32'd1, 2'b10);
      repeat (3) @(posedge clk);
      bus_write(6'd3, 32'h0000ABCD, 2'b10);
      n_checks++; if (user_interrupt !== 1'b0) begin n_fail++; $display("FAIL nowin_irq got %b exp 0", user_interrupt); end
      bus_read(6'd4, rd, rdy);
      n_checks++; if (rd !== 32'h23) begin n_fail++; $display("FAIL nowin_status got %h exp 23", rd); end
      bus_read(6'd7, rd, rdy);
      n_checks++; if (rd !== 32'd9) begin n_fail++; $display("FAIL nowin_count got %0d exp 9", rd); end
`endif
   endtask

   initial begin
      rst_n = 1'b0; ui_in = 8'h00; address = 6'd0; data_in = 32'h0;
      data_write_n = 2'b11; data_read_n = 2'b11;
      test_reset();
      test_basic_expiry();
      test_prescale_tap();
      test_grace_recovery();
      test_lock();
      test_reads();
      test_tap_vs_tick();
      test_window();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
